// File: rtl/cpu_bus_responder.sv
// -----------------------------------------------------------------------------
// cpu_bus_responder
//   Target side of the 6502 core's address bus. Each CPU bus cycle (a clk_ph2
//   pulse while rdy=1) is decoded to the mirrored 2 KB work RAM, the PPU
//   register window, the OAM-DMA trigger register or the external bus. PPU
//   accesses and OAM DMA stall the core by holding rdy low until complete.
//
// Ports
//   sys_clock, rst          : system clock, synchronous active-high reset
//   clk_ph2                 : one-cycle phase-2 enable marking a CPU bus cycle
//   ADLin, ADHin, rw        : CPU address (low/high byte) and direction (1=read)
//   data_in / data_out      : CPU write data / registered read data
//   rdy                     : 1 = core may advance, 0 = core holds its cycle
//   ppu_req/we/addr/wdata   : PPU request handshake (held until ppu_ack)
//   ppu_rdata, ppu_ack      : PPU read data and one-cycle completion pulse
//   ext_addr                : external bus address (combinational)
//   ext_we, ext_wdata       : one-cycle external write strobe and data
//   ext_rdata               : external read data (combinational, same cycle)
// -----------------------------------------------------------------------------
module cpu_bus_responder #(
    parameter int unsigned RAM_AW   = 11,
    parameter logic [15:0] DMA_ADDR = 16'h4014
) (
    input  logic        sys_clock,
    input  logic        rst,
    input  logic        clk_ph2,
    input  logic [7:0]  ADLin,
    input  logic [7:0]  ADHin,
    input  logic        rw,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        rdy,
    output logic        ppu_req,
    output logic        ppu_we,
    output logic [2:0]  ppu_addr,
    output logic [7:0]  ppu_wdata,
    input  logic [7:0]  ppu_rdata,
    input  logic        ppu_ack,
    output logic [15:0] ext_addr,
    output logic        ext_we,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PPU_WAIT = 2'd1,
        ST_DMA_RD   = 2'd2,
        ST_DMA_WAIT = 2'd3
    } state_t;

    state_t              state_r;
    logic [7:0]          page_r;
    logic [7:0]          idx_r;
    // Set once ppu_req has been visible for a full cycle; an ack in the very
    // cycle the request first appears is not counted.
    logic                ack_arm_r;
    logic [7:0]          ram_r [0:(1 << RAM_AW) - 1];

    logic [15:0]         cpu_addr_s;
    logic [15:0]         dma_src_s;
    logic                dma_active_s;
    logic                is_ram_s;
    logic                is_ppu_s;
    logic                is_dma_s;
    logic [RAM_AW-1:0]   ram_addr_s;
    logic [7:0]          ram_rdata_s;
    logic                ram_we_s;
    logic [7:0]          dma_byte_s;
    logic                ack_ok_s;

    assign cpu_addr_s   = {ADHin, ADLin};
    assign dma_src_s    = {page_r, idx_r};
    assign dma_active_s = (state_r == ST_DMA_RD) || (state_r == ST_DMA_WAIT);
    assign is_ram_s     = (cpu_addr_s[15:13] == 3'b000);
    assign is_ppu_s     = (cpu_addr_s[15:13] == 3'b001);
    assign is_dma_s     = (cpu_addr_s == DMA_ADDR) && (rw == 1'b0);
    assign ram_rdata_s  = ram_r[ram_addr_s];
    assign ram_we_s     = !rst && (state_r == ST_IDLE) && clk_ph2 && is_ram_s && (rw == 1'b0);
    assign ack_ok_s     = ppu_req && ack_arm_r && ppu_ack;

    // Bus address mux: the DMA engine owns the RAM and external address during a transfer.
    always_comb begin
        ext_addr   = cpu_addr_s;
        ram_addr_s = cpu_addr_s[RAM_AW-1:0];
        if (dma_active_s) begin
            ext_addr   = dma_src_s;
            ram_addr_s = dma_src_s[RAM_AW-1:0];
        end else begin
            ext_addr   = cpu_addr_s;
            ram_addr_s = cpu_addr_s[RAM_AW-1:0];
        end
    end

    // DMA source byte: RAM below page $20, zero for the PPU window, external above.
    always_comb begin
        dma_byte_s = 8'h00;
        if (dma_src_s[15:13] == 3'b000) begin
            dma_byte_s = ram_rdata_s;
        end else if (dma_src_s[15:13] == 3'b001) begin
            dma_byte_s = 8'h00;
        end else begin
            dma_byte_s = ext_rdata;
        end
    end

    // Work RAM storage; contents are intentionally not cleared by reset.
    always_ff @(posedge sys_clock) begin
        if (ram_we_s) begin
            ram_r[ram_addr_s] <= data_in;
        end
    end

    // Access sequencer: decode, PPU handshake, OAM DMA and all registered outputs.
    always_ff @(posedge sys_clock) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            page_r    <= 8'h00;
            idx_r     <= 8'h00;
            ack_arm_r <= 1'b0;
            data_out  <= 8'h00;
            rdy       <= 1'b1;
            ppu_req   <= 1'b0;
            ppu_we    <= 1'b0;
            ppu_addr  <= 3'd0;
            ppu_wdata <= 8'h00;
            ext_we    <= 1'b0;
            ext_wdata <= 8'h00;
        end else begin
            ext_we <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ack_arm_r <= 1'b0;
                    if (clk_ph2) begin
                        if (is_ram_s) begin
                            if (rw) begin
                                data_out <= ram_rdata_s;
                            end
                        end else if (is_ppu_s) begin
                            ppu_addr  <= cpu_addr_s[2:0];
                            ppu_we    <= ~rw;
                            ppu_wdata <= data_in;
                            ppu_req   <= 1'b1;
                            rdy       <= 1'b0;
                            state_r   <= ST_PPU_WAIT;
                        end else if (is_dma_s) begin
                            page_r  <= data_in;
                            idx_r   <= 8'h00;
                            rdy     <= 1'b0;
                            state_r <= ST_DMA_RD;
                        end else if (rw) begin
                            data_out <= ext_rdata;
                        end else begin
                            ext_we    <= 1'b1;
                            ext_wdata <= data_in;
                        end
                    end
                end
                ST_PPU_WAIT: begin
                    if (ack_ok_s) begin
                        ppu_req   <= 1'b0;
                        rdy       <= 1'b1;
                        ack_arm_r <= 1'b0;
                        state_r   <= ST_IDLE;
                        if (!ppu_we) begin
                            data_out <= ppu_rdata;
                        end
                    end else begin
                        ack_arm_r <= ppu_req;
                    end
                end
                ST_DMA_RD: begin
                    ack_arm_r <= 1'b0;
                    if (clk_ph2) begin
                        ppu_wdata <= dma_byte_s;
                        ppu_req   <= 1'b1;
                        ppu_we    <= 1'b1;
                        ppu_addr  <= 3'd4;
                        state_r   <= ST_DMA_WAIT;
                    end
                end
                ST_DMA_WAIT: begin
                    if (ack_ok_s) begin
                        ppu_req   <= 1'b0;
                        ack_arm_r <= 1'b0;
                        if (idx_r == 8'hFF) begin
                            rdy     <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            idx_r   <= idx_r + 8'd1;
                            state_r <= ST_DMA_RD;
                        end
                    end else begin
                        ack_arm_r <= ppu_req;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rdy       <= 1'b1;
                    ppu_req   <= 1'b0;
                    ack_arm_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Target side of the 6502 core's address bus. It samples the 16-bit address that the program counter and address logic drive, together with R/W and write data. Each access is decoded to the 2 KB internal work RAM, the PPU register window, the OAM-DMA register or the external (APU/cartridge) bus, and read data is returned to the core. PPU accesses and OAM DMA stall the core through `rdy` until they complete.

## Interface
- `RAM_AW`, 11: work-RAM address width; 2 KB, mirrored across $0000-$1FFF.
- `DMA_ADDR`, 16'h4014: address of the OAM-DMA trigger register.
- `sys_clock` in 1: main system clock. One clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clk_ph2` in 1: phase-2 clock enable, a one-`sys_clock` pulse. Each pulse while `rdy`=1 is one CPU bus cycle.
- `ADLin`, `ADHin` in 8 each: address bus low and high bytes from the core.
- `rw` in 1: 1 = read, 0 = write.
- `data_in` in 8: CPU write data.
- `data_out` out 8: registered read data to the CPU.
- `rdy` out 1: 1 = the core may advance; 0 = the core holds its address, R/W and data.
- `ppu_req` out 1: PPU access request, held until acknowledged.
- `ppu_we` out 1: 1 = PPU write.
- `ppu_addr` out 3: PPU register index.
- `ppu_wdata` out 8: PPU write data.
- `ppu_rdata` in 8: PPU read data, valid when `ppu_ack`=1.
- `ppu_ack` in 1: one-cycle completion pulse from the PPU.
- `ext_addr` out 16: external bus address (combinational).
- `ext_we` out 1: external write strobe, one `sys_clock` wide.
- `ext_wdata` out 8: external write data.
- `ext_rdata` in 8: external read data (combinational, same cycle).

## Operation
- Address A = {ADHin, ADLin}. Decode happens only on a `clk_ph2` pulse in state IDLE:
  - A < $2000: RAM[A[RAM_AW-1:0]]. A read loads `data_out`. A write stores `data_in`.
  - $2000 <= A < $4000: PPU access with `ppu_addr` = A[2:0]. The block latches `ppu_we` = ~`rw` and `ppu_wdata` = `data_in`, sets `ppu_req`=1 and `rdy`=0, and goes to PPU_WAIT.
  - A = DMA_ADDR with `rw`=0: page P <= `data_in`, index I <= 0, `rdy` <= 0, go to DMA_RD. A read of DMA_ADDR goes to the external bus instead.
  - Otherwise: external bus. `ext_addr` = A. A read loads `data_out` <= `ext_rdata`. A write pulses `ext_we` for one cycle with `ext_wdata` = `data_in`.
- PPU_WAIT:
  - `ppu_ack` is sampled only while `ppu_req`=1.
  - On ack, the block drops `ppu_req` and sets `rdy`=1. For a read it also loads `data_out` <= `ppu_rdata`.
  - It then returns to IDLE.
- DMA_RD:
  - On the next `clk_ph2`, the block reads source {P, I} through the same decode: RAM for P < $20, external otherwise.
  - A source in the PPU window ($20-$3F) reads as $00 and issues no PPU request.
  - The byte is latched into `ppu_wdata`, then `ppu_req`=1, `ppu_we`=1, `ppu_addr`=4, and the state moves to DMA_WAIT.
- DMA_WAIT:
  - On `ppu_ack`: drop `ppu_req`.
  - If I = 255: `rdy` <= 1, go to IDLE.
  - Otherwise: I <= I + 1 (8-bit), go to DMA_RD.
- During DMA, `ext_addr` = {P, I}. CPU-side `ADLin`, `ADHin`, `rw` and `data_in` are ignored.
- `data_out` holds its last value across writes and stalls.

## Timing
- Reset values:
  - `data_out`=$00, `rdy`=1, `ppu_req`=0, `ppu_we`=0, `ppu_addr`=0, `ppu_wdata`=$00, `ext_we`=0.
  - State IDLE, P=0, I=0.
  - RAM contents are not reset.
- RAM and external reads: `data_out` is valid on the `sys_clock` after the `clk_ph2` pulse. Zero stall.
- PPU access:
  - `ppu_req` and `rdy`=0 appear one `sys_clock` after `clk_ph2`.
  - `rdy`=1 and read data appear one `sys_clock` after the `ppu_ack` edge.
  - Minimum stall is 2 `sys_clock`.
- DMA: exactly 256 PPU writes, in ascending I order. `rdy` stays 0 from the cycle after the $4014 write until one cycle after the 256th ack.
- A `ppu_ack` that arrives with `ppu_req`=0 is ignored. An ack that arrives in the same cycle the request is raised is not counted.
- A `clk_ph2` pulse while `rdy`=0 does not start a new CPU access.
- `rst` asserted in any state, including mid-DMA or PPU_WAIT: all outputs return to their reset values on the next edge, the DMA is aborted and `ppu_req` is dropped without waiting for an ack.

## Test plan
- Write $5A to $0005, then read $0805 (mirror) -> `data_out`=$5A one cycle after the ph2 pulse, `rdy` never low.
- Read $2002 with the PPU returning $80 and acking 3 cycles after the request -> `ppu_addr`=2, `ppu_we`=0, `rdy` low 4 cycles, `data_out`=$80.
- Write $A1 to $3FF9 -> `ppu_addr`=1, `ppu_we`=1, `ppu_wdata`=$A1, `rdy` released the cycle after ack.
- Preload RAM $0200-$02FF with I^$FF, then write $02 to $4014 with an immediate PPU ack -> 256 writes to `ppu_addr`=4 with data $FF down to $00, then `rdy`=1.
- Assert `rst` during DMA at I=$40 -> next cycle `ppu_req`=0, `rdy`=1; a following $0000 read behaves normally.
- Write $77 to $6000 -> one-cycle `ext_we`, `ext_addr`=$6000, `ext_wdata`=$77; read $4016 with `ext_rdata`=$41 -> `data_out`=$41.
